iir_decimator: RTL and testbench
================================

IIR_DECIMATOR -- requirements
Module: iir_decimator

Interface
REQ-001 Parameter NB_DATA, default 8, sample width in bits (two's complement).
REQ-002 Parameter LOG2_DEC, default 2, decimation factor D = 2^LOG2_DEC, legal range 1..4.
REQ-003 Parameter LOG2_DEPTH, default 2, output FIFO depth = 2^LOG2_DEPTH entries.
REQ-004 i_clk  in  1  single clock; all state changes on rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_clr  in  1  synchronous clear of accumulator, counter, FIFO and overflow flag.
REQ-007 i_valid  in  1  i_data holds a filter output sample this cycle.
REQ-008 i_data  in  NB_DATA  signed sample from the upstream IIR stage.
REQ-009 i_ready  in  1  downstream accepts o_data this cycle.
REQ-010 o_valid  out  1  o_data holds a decimated sample (FIFO not empty).
REQ-011 o_data  out  NB_DATA  signed block-average at the FIFO head.
REQ-012 o_overflow  out  1  sticky: a result was dropped because the FIFO was full.

Function
REQ-013 Block SHALL accept a sample on every edge with i_valid=1; no upstream back-pressure exists, so samples are never stalled.
REQ-014 Sample counter SHALL run 0..D-1, advance only on accepted samples, and wrap to 0 after D-1.
REQ-015 Accumulator width SHALL be NB_DATA+LOG2_DEC bits, sign-extended inputs, no saturation needed.
REQ-016 On the sample with count D-1: result = (acc + i_data) arithmetic-shifted right by LOG2_DEC (floor), truncated to NB_DATA bits; result is pushed to the FIFO on that edge, and acc is loaded with 0 on that edge.
REQ-017 On other accepted samples, acc SHALL load acc + i_data.
REQ-018 Latency: o_valid SHALL rise on the edge that follows the cycle holding the D-th sample (empty FIFO, no fall-through).
REQ-019 A pop SHALL occur on an edge with o_valid=1 and i_ready=1; o_data/o_valid change only after a pop or a push.
REQ-020 Gaps in i_valid SHALL NOT affect group membership or arithmetic.
REQ-021 Push while FIFO full and no pop: result dropped, FIFO contents unchanged, o_overflow set.
REQ-022 Push and pop on the same edge while full: both SHALL occur; no overflow.
REQ-023 Push and pop on the same edge while holding one entry: new result becomes head; o_valid stays 1.
REQ-024 o_overflow SHALL remain 1 until i_clr or reset.
REQ-025 i_clr SHALL take priority over any push/pop on the same edge; the i_valid sample on that edge is discarded.
REQ-026 FIFO pointers SHALL be LOG2_DEPTH+1 bits; full/empty derived from pointer MSB comparison.

Reset
REQ-027 On i_rst_n=0: acc=0, count=0, FIFO read/write pointers=0, o_valid=0, o_overflow=0, o_data=0; applied asynchronously, released synchronously to i_clk.
REQ-028 Reset asserted mid-group SHALL discard the partial sum; the first accepted sample after release begins a new group.
REQ-029 FIFO storage array requires no reset.

Structure
REQ-030 Shared package holds NB_DATA default and the arithmetic-shift/sign-extend width constants used by filter-chain blocks.
REQ-031 One sub-module, sync_fifo (parameters width, LOG2_DEPTH; push/pop/full/empty/clr), instantiated once.

Verification
REQ-032 D=4, i_ready=1, samples 1,2,3,4 consecutive -> o_data=2 valid exactly one cycle after sample 4.
REQ-033 Samples 0xFF,0xFF,0xFF,0xFE (-1,-1,-1,-2) -> o_data=0xFE (-2, floor of -1.25).
REQ-034 Samples 5,7,9,11 with one idle cycle between each -> o_data=8, one result only.
REQ-035 i_ready=0, depth 4, 5 full groups -> 4 entries retained in order, o_overflow=1; then i_ready=1 drains exactly 4 results.
REQ-036 FIFO full, 5th group completes on same edge as pop -> no overflow, FIFO stays full, order preserved.
REQ-037 Reset asserted after 2 samples of a group, released, samples 4,4,4,4 -> o_data=4; i_clr asserted mid-operation -> o_valid=0, o_overflow=0 next cycle.

Source files
------------

// File: rtl/iir_decimator_pkg.sv
// Shared constants for filter-chain blocks: default sample width, decimation
// limits and the accumulator width that holds a block sum of sign-extended
// samples.
package iir_decimator_pkg;

   localparam int unsigned NB_DATA_DEF    = 8;
   localparam int unsigned LOG2_DEC_DEF   = 2;
   localparam int unsigned LOG2_DEPTH_DEF = 2;
   localparam int unsigned LOG2_DEC_MIN   = 1;
   localparam int unsigned LOG2_DEC_MAX   = 4;

   // A sum of 2^log2_dec samples needs log2_dec extra bits to avoid overflow.
   function automatic int unsigned acc_width(input int unsigned nb_data,
                                             input int unsigned log2_dec);
      return nb_data + log2_dec;
   endfunction

   // Number of sign-extension bits added to a sample before accumulation.
   function automatic int unsigned sext_bits(input int unsigned log2_dec);
      return log2_dec;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head data and registered full/empty flags.
// Pointers carry one extra wrap bit; full/empty compare pointer MSBs.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_clr           synchronous clear (priority over push/pop)
//   i_push, i_data  write request and data (ignored when full unless popping)
//   i_pop           read request (ignored when empty)
//   o_data          head entry, o_full / o_empty status
module sync_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned LOG2_DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PTR_W = LOG2_DEPTH + 1;
   localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
   logic             do_push, do_pop;
   logic             empty_nxt, full_nxt;
   logic [WIDTH-1:0] head_nxt;

   // Qualified requests and next pointer/flag/head values.
   always_comb begin
      do_pop    = i_pop & ~o_empty;
      do_push   = i_push & (~o_full | do_pop);
      rd_nxt    = rd_ptr + PTR_W'(do_pop);
      wr_nxt    = wr_ptr + PTR_W'(do_push);
      empty_nxt = (rd_nxt == wr_nxt);
      full_nxt  = (rd_nxt[PTR_W-1] != wr_nxt[PTR_W-1]) &&
                  (rd_nxt[LOG2_DEPTH-1:0] == wr_nxt[LOG2_DEPTH-1:0]);
      head_nxt  = o_data;
      // Entry being written this edge becomes head when it lands at rd_nxt.
      if (do_push && (rd_nxt == wr_ptr))
         head_nxt = i_data;
      else if (!empty_nxt)
         head_nxt = mem[rd_nxt[LOG2_DEPTH-1:0]];
   end

   // Storage needs no reset; head and flags are tracked in registers.
   always_ff @(posedge i_clk) begin
      if (do_push && !i_clr)
         mem[wr_ptr[LOG2_DEPTH-1:0]] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         o_empty <= 1'b1;
         o_full  <= 1'b0;
         o_data  <= '0;
      end else if (i_clr) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         o_empty <= 1'b1;
         o_full  <= 1'b0;
         o_data  <= '0;
      end else begin
         rd_ptr  <= rd_nxt;
         wr_ptr  <= wr_nxt;
         o_empty <= empty_nxt;
         o_full  <= full_nxt;
         o_data  <= head_nxt;
      end
   end

endmodule

// File: rtl/iir_decimator.sv
// Block-average decimator: sums D = 2^LOG2_DEC accepted samples, emits the
// floored mean into an output FIFO and restarts the group.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_clr               synchronous clear of accumulator, counter, FIFO, flag
//   i_valid, i_data     upstream samples (never stalled)
//   i_ready             downstream accepts o_data
//   o_valid, o_data     FIFO head
//   o_overflow          sticky: a result was dropped on a full FIFO
module iir_decimator
   import iir_decimator_pkg::*;
#(
   parameter int unsigned NB_DATA    = NB_DATA_DEF,
   parameter int unsigned LOG2_DEC   = LOG2_DEC_DEF,
   parameter int unsigned LOG2_DEPTH = LOG2_DEPTH_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_clr,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_ready,
   output logic               o_valid,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_overflow
);

   localparam int unsigned ACC_W = acc_width(NB_DATA, LOG2_DEC);
   localparam int unsigned EXT_W = sext_bits(LOG2_DEC);
   localparam int unsigned DEC   = 1 << LOG2_DEC;

   logic signed [ACC_W-1:0]   acc, sum, data_ext;
   logic [LOG2_DEC-1:0]       count;
   logic                      last, push, pop;
   logic                      fifo_full, fifo_empty;
   logic [NB_DATA-1:0]        result;

   // Group sum including the current sample, and its floored mean.
   always_comb begin
      data_ext = {{EXT_W{i_data[NB_DATA-1]}}, i_data};
      sum      = acc + data_ext;
      result   = NB_DATA'(sum >>> LOG2_DEC);
      last     = (count == LOG2_DEC'(DEC - 1));
      push     = i_valid & last;
      pop      = o_valid & i_ready;
   end

   // Accumulator and sample counter advance only on accepted samples.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc   <= '0;
         count <= '0;
      end else if (i_clr) begin
         acc   <= '0;
         count <= '0;
      end else if (i_valid) begin
         if (last) begin
            acc   <= '0;
            count <= '0;
         end else begin
            acc   <= sum;
            count <= count + LOG2_DEC'(1);
         end
      end
   end

   // Sticky drop flag: a pop on the same edge frees a slot, so no drop then.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_overflow <= 1'b0;
      else if (i_clr)
         o_overflow <= 1'b0;
      else if (push && fifo_full && !pop)
         o_overflow <= 1'b1;
   end

   sync_fifo #(
      .WIDTH      (NB_DATA),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_clr),
      .i_push  (push),
      .i_pop   (pop),
      .i_data  (result),
      .o_data  (o_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   assign o_valid = ~fifo_empty;

endmodule

// File: tb/tb_iir_decimator.sv
module tb_iir_decimator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ovf;

   int total = 0;
   int bad   = 0;
   int n_pop = 0;
   logic [7:0] sb[$];

   iir_decimator #(.NB_DATA(8), .LOG2_DEC(2), .LOG2_DEPTH(2)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_clr      (clr),
      .i_valid    (in_valid),
      .i_data     (in_data),
      .i_ready    (in_ready),
      .o_valid    (out_valid),
      .o_data     (out_data),
      .o_overflow (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every output the DUT hands over is compared with the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && in_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: got %0d expected none", out_data);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (out_data != e) begin
               bad++;
               $display("FAIL output_data: got %0d expected %0d", out_data, e);
            end
         end
         n_pop++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic group4(input logic [7:0] d);
      repeat (4) send(d);
   endtask

   // Drain with ready high until the FIFO is empty, bounded.
   task automatic drain(input string name, input int exp_pops);
      int start;
      int cyc;
      start = n_pop;
      in_ready = 1'b1;
      cyc = 0;
      while (out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      chk({name, "_drain_timeout"}, int'(out_valid), 0);
      chk({name, "_pops"}, n_pop - start, exp_pops);
   endtask

   initial begin
      int p0;
      repeat (3) tick();
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_data", int'(out_data), 0);
      chk("reset_ovf", int'(out_ovf), 0);
      rst_n = 1'b1;
      tick();

      // 1,2,3,4 -> 2, valid right after the 4th sample edge
      in_ready = 1'b1;
      send(8'd1); send(8'd2); send(8'd3);
      chk("lat_before", int'(out_valid), 0);
      sb.push_back(8'd2);
      send(8'd4);
      chk("lat_valid", int'(out_valid), 1);
      chk("lat_data", int'(out_data), 2);
      tick();
      chk("lat_popped", int'(out_valid), 0);

      // -1,-1,-1,-2 -> floor(-1.25) = -2
      send(8'hFF); send(8'hFF); send(8'hFF);
      sb.push_back(8'hFE);
      send(8'hFE);
      chk("neg_data", int'(out_data), 8'hFE);
      tick();

      // gaps between samples: 5,7,9,11 -> 8, exactly one result
      p0 = n_pop;
      send(8'd5); tick(); send(8'd7); tick(); send(8'd9); tick();
      chk("gap_no_early", int'(out_valid), 0);
      sb.push_back(8'd8);
      send(8'd11);
      repeat (6) tick();
      chk("gap_one_result", n_pop - p0, 1);

      // ready low, 5 groups into depth 4: first four kept, fifth dropped
      in_ready = 1'b0;
      sb.push_back(8'd10); group4(8'd10);
      sb.push_back(8'd20); group4(8'd20);
      sb.push_back(8'd30); group4(8'd30);
      sb.push_back(8'd40); group4(8'd40);
      chk("full_no_ovf_yet", int'(out_ovf), 0);
      group4(8'd50);
      chk("ovf_set", int'(out_ovf), 1);
      chk("ovf_head", int'(out_data), 10);
      drain("ovf", 4);
      chk("ovf_sticky", int'(out_ovf), 1);
      chk("ovf_sb_empty", sb.size(), 0);

      // clear flag, then full FIFO with push and pop on the same edge
      in_ready = 1'b0;
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_ovf", int'(out_ovf), 0);
      sb.push_back(8'd8);  group4(8'd8);
      sb.push_back(8'd16); group4(8'd16);
      sb.push_back(8'd24); group4(8'd24);
      sb.push_back(8'd32); group4(8'd32);
      send(8'd40); send(8'd40); send(8'd40);
      p0 = n_pop;
      sb.push_back(8'd40);
      in_ready = 1'b1;
      send(8'd40);
      in_ready = 1'b0;
      chk("pp_one_pop", n_pop - p0, 1);
      chk("pp_no_ovf", int'(out_ovf), 0);
      chk("pp_head", int'(out_data), 16);
      drain("pp", 4);
      chk("pp_sb_empty", sb.size(), 0);

      // reset mid-group discards the partial sum
      send(8'd100); send(8'd100);
      rst_n = 1'b0; tick(); tick();
      rst_n = 1'b1; tick();
      chk("rst_valid", int'(out_valid), 0);
      in_ready = 1'b1;
      send(8'd4); send(8'd4); send(8'd4);
      sb.push_back(8'd4);
      send(8'd4);
      chk("rst_group_valid", int'(out_valid), 1);
      chk("rst_group_data", int'(out_data), 4);
      tick();

      // clear mid-operation with pending results and overflow set
      in_ready = 1'b0;
      repeat (5) group4(8'd3);
      send(8'd60); send(8'd60);
      chk("pre_clr_ovf", int'(out_ovf), 1);
      chk("pre_clr_valid", int'(out_valid), 1);
      clr = 1'b1; in_valid = 1'b1; in_data = 8'd60;
      tick();
      clr = 1'b0; in_valid = 1'b0;
      chk("clr_valid", int'(out_valid), 0);
      chk("clr_ovf2", int'(out_ovf), 0);
      chk("clr_data", int'(out_data), 0);
      // new group after clear must not include the discarded samples
      in_ready = 1'b1;
      send(8'd12); send(8'd12); send(8'd12);
      chk("clr_new_group_wait", int'(out_valid), 0);
      sb.push_back(8'd12);
      send(8'd12);
      chk("clr_new_group", int'(out_data), 12);
      repeat (3) tick();
      chk("final_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
